// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared types and the misalign rule for the sized data memory
package dmem_pkg;

    typedef enum logic [1:0] {
        SZ_B   = 2'b00,
        SZ_H   = 2'b01,
        SZ_W   = 2'b10,
        SZ_RSV = 2'b11
    } mem_size_t;

    typedef enum logic {
        ST_INIT  = 1'b0,
        ST_READY = 1'b1
    } dmem_state_t;

    // Only asserted when an access is actually requested; the reserved size is always illegal.
    function automatic logic is_misaligned(
        input logic      we,
        input logic      re,
        input mem_size_t sz,
        input logic [1:0] a_lo
    );
        logic bad;
        case (sz)
            SZ_H:    bad = a_lo[0];
            SZ_W:    bad = (a_lo != 2'b00);
            SZ_RSV:  bad = 1'b1;
            default: bad = 1'b0;
        endcase
        return (we | re) & bad;
    endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// rtl/dmem_lane_align.sv - byte-lane strobe, store replication and load extraction/extension
module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic [1:0]  size_i,
    input  logic [1:0]  addr_lo_i,
    input  logic        uns_i,
    input  logic [31:0] wd_i,
    input  logic [31:0] raw_i,
    output logic [3:0]  strb_o,
    output logic [31:0] wdata_o,
    output logic [31:0] rdata_o
);

    mem_size_t   sz;
    logic [31:0] shifted;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    assign sz       = mem_size_t'(size_i);
    assign shifted  = raw_i >> {addr_lo_i, 3'b000};
    assign byte_sel = shifted[7:0];
    assign half_sel = addr_lo_i[1] ? raw_i[31:16] : raw_i[15:0];

    // Store data is replicated across lanes so the strobe alone selects what lands.
    always_comb begin
        strb_o  = 4'b0000;
        wdata_o = wd_i;
        rdata_o = 32'h0;
        case (sz)
            SZ_B: begin
                strb_o  = 4'b0001 << addr_lo_i;
                wdata_o = {4{wd_i[7:0]}};
                rdata_o = {{24{~uns_i & byte_sel[7]}}, byte_sel};
            end
            SZ_H: begin
                strb_o  = addr_lo_i[1] ? 4'b1100 : 4'b0011;
                wdata_o = {2{wd_i[15:0]}};
                rdata_o = {{16{~uns_i & half_sel[15]}}, half_sel};
            end
            SZ_W: begin
                strb_o  = 4'b1111;
                wdata_o = wd_i;
                rdata_o = raw_i;
            end
            default: begin
                strb_o  = 4'b0000;
                wdata_o = wd_i;
                rdata_o = 32'h0;
            end
        endcase
    end

endmodule

// File: rtl/data_memory_sized.sv
// rtl/data_memory_sized.sv - byte-addressed data memory with sized access and post-reset fill
module data_memory_sized
    import dmem_pkg::*;
#(
    parameter int DEPTH     = 32,
    parameter int ADDR_W    = 32,
    parameter int INIT_MODE = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] A,
    input  logic [31:0]       WD,
    input  logic              WE,
    input  logic              RE,
    input  logic [1:0]        size,
    input  logic              uns,
    output logic [31:0]       RD,
    output logic              misalign,
    output logic              ready,
    output logic [31:0]       probe_dm
);

    localparam int IDX_W = $clog2(DEPTH);

    logic [31:0]      mem_q [DEPTH];
    dmem_state_t      state_q;
    logic [IDX_W-1:0] cnt_q;

    logic [IDX_W-1:0] idx;
    logic [31:0]      raw;
    logic             ready_w;
    logic             mis_w;
    logic [3:0]       strb;
    logic [31:0]      wdata;
    logic [31:0]      rdata;

    assign idx     = A[IDX_W+1:2];
    assign raw     = mem_q[idx];
    assign ready_w = (state_q == ST_READY);
    assign mis_w   = is_misaligned(WE, RE, mem_size_t'(size), A[1:0]);

    generate
        if (ADDR_W > IDX_W + 2) begin : g_alias
            logic unused_upper_addr;
            assign unused_upper_addr = ^A[ADDR_W-1:IDX_W+2];
        end
    endgenerate

    dmem_lane_align u_align (
        .size_i    (size),
        .addr_lo_i (A[1:0]),
        .uns_i     (uns),
        .wd_i      (WD),
        .raw_i     (raw),
        .strb_o    (strb),
        .wdata_o   (wdata),
        .rdata_o   (rdata)
    );

    assign ready    = ready_w;
    assign misalign = ready_w & mis_w;
    assign RD       = (ready_w && !mis_w) ? rdata : 32'h0;
    assign probe_dm = ready_w ? raw : 32'h0;

    // Reset never touches the array; the fill sequence owns it until READY.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_INIT;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                ST_INIT: begin
                    mem_q[cnt_q] <= (INIT_MODE != 0) ? 32'(cnt_q) : 32'h0;
                    if (cnt_q == IDX_W'(DEPTH - 1)) begin
                        state_q <= ST_READY;
                    end else begin
                        cnt_q <= cnt_q + IDX_W'(1);
                    end
                end
                ST_READY: begin
                    if (WE && !mis_w) begin
                        for (int b = 0; b < 4; b++) begin
                            if (strb[b]) begin
                                mem_q[idx][b*8 +: 8] <= wdata[b*8 +: 8];
                            end
                        end
                    end
                end
                default: state_q <= ST_INIT;
            endcase
        end
    end

endmodule

// File: doc/data_memory_sized.md
Name: data_memory_sized

Overview:
- Parametrised, byte-addressed data memory for the single-cycle core, replacing the fixed 32x32 word memory.
- Supports byte, half-word and word loads and stores, with sign or zero extension on loads.
- Detects misaligned accesses and suppresses writes for them.
- Runs a post-reset initialisation sequencer that fills the array one word per cycle and holds `ready` low until done.

Parameters:
- DEPTH, 32, number of 32-bit words (power of two, >=2)
- ADDR_W, 32, byte-address width on port A
- INIT_MODE, 1, fill pattern: 0 = all zero, 1 = mem[i] = i

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- A  in  ADDR_W  byte address
- WD  in  32  store data, right-aligned
- WE  in  1  store enable
- RE  in  1  load enable (qualifies misalign only)
- size  in  2  00 byte, 01 half, 10 word, 11 reserved
- uns  in  1  1 = zero-extend load, 0 = sign-extend
- RD  out  32  load data, extended
- misalign  out  1  current access is illegal
- ready  out  1  init complete, accesses honoured
- probe_dm  out  32  raw word at the word index of A (debug)

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Word index = A[$clog2(DEPTH)+1:2]. Upper address bits are ignored, so addresses alias modulo DEPTH*4.
- FSM states: INIT, READY.
- While rst=1 at a clk edge: state<=INIT, cnt<=0. The array is not modified on that edge.
- INIT, each edge with rst=0:
  - mem[cnt] <= (INIT_MODE ? cnt : 0).
  - If cnt==DEPTH-1, go to READY; else cnt<=cnt+1.
  - ready therefore rises exactly DEPTH edges after rst deasserts.
- Reset in the middle of INIT or READY restarts the sequence from cnt=0.
- In INIT: ready=0, RD=0, misalign=0, probe_dm=0. WE is ignored.
- In READY, ready=1 (registered from the state).
- Misalign rule (combinational, READY only): misalign = (WE|RE) & ((size==01 & A[0]) | (size==10 & A[1:0]!=0) | size==11).
- Stores (READY, WE=1, misalign=0), written at the clk edge:
  - byte: WD[7:0] into lane A[1:0].
  - half: WD[15:0] into lanes {A[1],0} and {A[1],1}.
  - word: all four lanes.
  - Unwritten lanes keep their value.
- A misaligned store writes nothing.
- Loads are combinational from the current array contents:
  - byte/half: extract the addressed lane(s), then extend per uns.
  - word: full word; uns is ignored.
  - Misaligned access: RD=0.
  - RD is valid whether or not RE is asserted; RE only gates misalign.
- Simultaneous WE and read of the same word: RD shows the old data until the edge, then the new data (no bypass).
- probe_dm is the raw word at the word index of A, without extraction or misalign gating.

Decomposition:
- Package dmem_pkg holds:
  - typedef enum logic [1:0] mem_size_t {SZ_B, SZ_H, SZ_W, SZ_RSV}
  - typedef enum logic {ST_INIT, ST_READY} dmem_state_t
  - the misalign check as a function.
- One combinational sub-module, dmem_lane_align:
  - Inputs: size, A[1:0], uns, WD, raw word.
  - Outputs: 4-bit byte strobe, lane-aligned write word, extended load data.
- The top level holds the array, the FSM and the counter.

Test Plan:
- Reset/init:
  - Hold rst=1 for 2 cycles, then release.
  - ready=0 for exactly 32 edges, then 1.
  - Word load at A=0x0C gives RD=0x00000003.
  - RD=0 throughout INIT even with A=0x0C.
- Byte store and signed/unsigned load:
  - After init, byte store WD=0x000000A5 at A=0x11.
  - probe_dm at A=0x10 = 0x0000A504.
  - Byte load A=0x11 with uns=0 gives 0xFFFFFFA5; with uns=1 gives 0x000000A5.
- Half store and load:
  - Half store WD=0x00008001 at A=0x16.
  - Word at 0x14 = 0x80010005.
  - Half load A=0x16 with uns=0 gives 0xFFFF8001.
- Misalign:
  - Half store at A=0x13 with WD=0xFFFF gives misalign=1; word 4 unchanged.
  - Word load at A=0x02 gives misalign=1, RD=0.
  - size=11 with WE=1 gives misalign=1 and no write.
- Aliasing and WE during INIT:
  - Word store 0xDEADBEEF at A=0x80 (DEPTH=32) gives word 0 = 0xDEADBEEF.
  - WE=1 at A=0x04 during INIT has no effect: word 1 = 1 after ready.
- Reset mid-operation:
  - After the stores above, pulse rst for 1 cycle mid-READY.
  - ready drops next edge and returns 32 edges later.
  - Word 4 reads 0x00000004 and word 0 reads 0x00000000.
